// File: rtl/aes_usb_pkg.sv
// Shared types and sizes for the USB-to-AES datapath.
package aes_usb_pkg;

  localparam int BYTE_W          = 8;
  localparam int BLOCK_W         = 128;
  localparam int BYTES_PER_BLOCK = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packer_state_e;

endpackage

// File: rtl/flex_fifo.sv
// First-word-fall-through FIFO: r_data shows the head entry whenever empty is low.
module flex_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]    mem_d [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 push, pop;

  assign full   = (count_q == DEPTH_CNT);
  assign empty  = (count_q == '0);
  assign r_data = mem_q[rd_ptr_q];

  // A write into a full FIFO is dropped even if a pop happens on the same edge.
  assign push = w_enable && !full;
  assign pop  = r_enable && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = w_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/plaintext_packer.sv
// Packs plaintext bytes from the USB receive path into 128-bit blocks for the AES core.
module plaintext_packer
  import aes_usb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               w_enable,
  input  logic [BYTE_W-1:0]  w_data,
  input  logic               clear,
  input  logic               block_ack,
  output logic               full,
  output logic               block_valid,
  output logic [BLOCK_W-1:0] block_data,
  output logic [4:0]         byte_count
);

  localparam logic [4:0] LAST_BYTE = 5'(BYTES_PER_BLOCK - 1);

  packer_state_e      state_q, state_d;
  logic [BLOCK_W-1:0] block_data_q, block_data_d;
  logic [4:0]         byte_count_q, byte_count_d;
  logic               block_valid_q, block_valid_d;
  logic               fifo_r_enable;
  logic               fifo_empty;
  logic [BYTE_W-1:0]  fifo_r_data;

  flex_fifo #(
    .DATA_W     (BYTE_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_enable (fifo_r_enable),
    .r_data   (fifo_r_data),
    .empty    (fifo_empty),
    .full     (full)
  );

  // clear wins over both ack and pop; the FIFO itself keeps its contents.
  always_comb begin
    state_d       = state_q;
    block_data_d  = block_data_q;
    byte_count_d  = byte_count_q;
    block_valid_d = block_valid_q;
    fifo_r_enable = 1'b0;
    if (clear) begin
      state_d       = COLLECT;
      block_data_d  = '0;
      byte_count_d  = '0;
      block_valid_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (!fifo_empty) begin
            fifo_r_enable = 1'b1;
            block_data_d  = {block_data_q[BLOCK_W-BYTE_W-1:0], fifo_r_data};
            byte_count_d  = byte_count_q + 5'd1;
            if (byte_count_q == LAST_BYTE) begin
              state_d       = HOLD;
              block_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (block_ack) begin
            state_d       = COLLECT;
            byte_count_d  = '0;
            block_valid_d = 1'b0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= COLLECT;
      block_data_q  <= '0;
      byte_count_q  <= '0;
      block_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      block_data_q  <= block_data_d;
      byte_count_q  <= byte_count_d;
      block_valid_q <= block_valid_d;
    end
  end

  assign block_valid = block_valid_q;
  assign block_data  = block_data_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_plaintext_packer.sv
// Scoreboard bench: expected blocks are queued by the stimulus, a monitor checks them on each accepted handshake.
module tb_plaintext_packer;

  logic         clk;
  logic         n_rst;
  logic         w_enable;
  logic [7:0]   w_data;
  logic         clear;
  logic         block_ack;
  logic         full;
  logic         block_valid;
  logic [127:0] block_data;
  logic [4:0]   byte_count;

  int           testsRun    = 0;
  int           testsFailed = 0;
  logic [127:0] expectedQ[$];
  logic [127:0] expBlock;
  logic [127:0] clearBlock;

  plaintext_packer #(
    .FIFO_DEPTH (16),
    .ADDR_BITS  (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .w_enable    (w_enable),
    .w_data      (w_data),
    .clear       (clear),
    .block_ack   (block_ack),
    .full        (full),
    .block_valid (block_valid),
    .block_data  (block_data),
    .byte_count  (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] data, input logic clr, input logic ack);
    w_enable  = we;
    w_data    = data;
    clear     = clr;
    block_ack = ack;
    tick();
    w_enable  = 1'b0;
    clear     = 1'b0;
    block_ack = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!block_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput(name, {127'd0, block_valid}, 128'd1);
  endtask

  function automatic logic [127:0] seqBlock(input logic [7:0] first);
    logic [127:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], first + 8'(i)};
    return b;
  endfunction

  // Monitor: every accepted block is compared against the oldest expected block.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && block_valid === 1'b1 && block_ack === 1'b1) begin
      if (expectedQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected block: got %h, expected no block", block_data);
      end else begin
        expBlock = expectedQ.pop_front();
        checkOutput("block data", block_data, expBlock);
        checkOutput("block byte_count", {123'd0, byte_count}, 128'd16);
      end
    end
  end

  initial begin
    n_rst     = 1'b0;
    w_enable  = 1'b0;
    w_data    = 8'h00;
    clear     = 1'b0;
    block_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset full", {127'd0, full}, 128'd0);
    checkOutput("reset valid", {127'd0, block_valid}, 128'd0);
    checkOutput("reset data", block_data, 128'd0);
    checkOutput("reset count", {123'd0, byte_count}, 128'd0);
    n_rst = 1'b1;
    tick();

    // Reset with eight bytes already packed
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    tick();
    checkOutput("count before reset", {123'd0, byte_count}, 128'd8);
    n_rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset data", block_data, 128'd0);
    checkOutput("mid reset count", {123'd0, byte_count}, 128'd0);
    checkOutput("mid reset valid", {127'd0, block_valid}, 128'd0);
    checkOutput("mid reset full", {127'd0, full}, 128'd0);
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    checkOutput("fifo empty after reset", {123'd0, byte_count}, 128'd0);

    // 0x00..0x0F back to back; valid rises one cycle after the last pop
    expectedQ.push_back(128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("count after 15 pops", {123'd0, byte_count}, 128'd15);
    checkOutput("valid before last pop", {127'd0, block_valid}, 128'd0);
    tick();
    checkOutput("valid cycle 17", {127'd0, block_valid}, 128'd1);
    checkOutput("count full block", {123'd0, byte_count}, 128'd16);
    checkOutput("first block data", block_data, 128'h000102030405060708090A0B0C0D0E0F);

    // Held block, FIFO fills with 0x10..0x1F and drops 0x20..0x23
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == 14) checkOutput("full after 15 writes", {127'd0, full}, 128'd0);
      if (i == 15) checkOutput("full after 16 writes", {127'd0, full}, 128'd1);
    end
    checkOutput("full while held", {127'd0, full}, 128'd1);
    checkOutput("count frozen in hold", {123'd0, byte_count}, 128'd16);

    // Ack, then ack the next block in the very cycle it becomes valid
    expectedQ.push_back(seqBlock(8'h10));
    expectedQ.push_back(seqBlock(8'h40));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("valid after ack", {127'd0, block_valid}, 128'd0);
    checkOutput("count after ack", {123'd0, byte_count}, 128'd0);
    checkOutput("full until pop", {127'd0, full}, 128'd1);
    for (int i = 1; i <= 17; i++) begin
      if (i == 16) begin
        checkOutput("count before 16th pop", {123'd0, byte_count}, 128'd15);
        checkOutput("valid before 16th pop", {127'd0, block_valid}, 128'd0);
      end
      if (i == 17) checkOutput("second block valid", {127'd0, block_valid}, 128'd1);
      applyStimulus(i >= 2, 8'h40 + 8'(i - 2), 1'b0, i == 17);
    end
    checkOutput("valid after rise ack", {127'd0, block_valid}, 128'd0);
    checkOutput("count after rise ack", {123'd0, byte_count}, 128'd0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j == 15) checkOutput("valid 16 cycles after ack", {127'd0, block_valid}, 128'd0);
      if (j == 16) checkOutput("valid 17 cycles after ack", {127'd0, block_valid}, 128'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("dropped bytes absent", {123'd0, byte_count}, 128'd0);
    checkOutput("full cleared", {127'd0, full}, 128'd0);

    // clear with a simultaneous write of 0xAA
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    tick();
    checkOutput("count before clear", {123'd0, byte_count}, 128'd5);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("clear count", {123'd0, byte_count}, 128'd0);
    checkOutput("clear data", block_data, 128'd0);
    checkOutput("clear valid", {127'd0, block_valid}, 128'd0);
    tick();
    checkOutput("count after AA pop", {123'd0, byte_count}, 128'd1);
    checkOutput("AA popped", {120'd0, block_data[7:0]}, 128'hAA);
    clearBlock = 128'hAA;
    for (int i = 0; i < 15; i++) clearBlock = {clearBlock[119:0], 8'h60 + 8'(i)};
    expectedQ.push_back(clearBlock);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    waitValid("clear block valid");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Ack during COLLECT is ignored
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("count before stray ack", {123'd0, byte_count}, 128'd7);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("count after stray ack", {123'd0, byte_count}, 128'd7);
    checkOutput("valid after stray ack", {127'd0, block_valid}, 128'd0);
    tick();
    checkOutput("count idle after stray ack", {123'd0, byte_count}, 128'd7);
    expectedQ.push_back(seqBlock(8'h70));
    for (int i = 7; i < 16; i++) applyStimulus(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    waitValid("stray ack block valid");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();

    checkOutput("scoreboard drained", 128'(expectedQ.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
